// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write-port controller.
//   DEF_XLEN / DEF_ADDR_W : default data and register-address widths
//   NUM_REGS              : register file depth for the default address width
//   state_e               : controller FSM states (clear walk, normal operation)
//   req_id_e              : write-port requester identities
package regfile_pkg;

   localparam int DEF_XLEN   = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Values double as the bit index of each requester in req/grant vectors.
   typedef enum logic {
      REQ_EX  = 1'b0,
      REQ_MEM = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request vector, bit 0 = EX, bit 1 = MEM
//   advance    : grant was consumed this cycle; update the last-grant record
//   grant[1:0] : one-hot (or zero) combinational grant
// The last-grant register resets to MEM so EX wins the first tie.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   req_id_e last_r;

   // Grant selection: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            if (last_r == REQ_MEM) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
         end
         default: grant = 2'b00;
      endcase
   end

   // Last-grant record, updated only when a grant is actually consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_r <= REQ_MEM;
      end else if (advance && grant[0]) begin
         last_r <= REQ_EX;
      end else if (advance && grant[1]) begin
         last_r <= REQ_MEM;
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: write-port controller and hazard scoreboard for the CPU register file.
//   After reset it clears x1..x(2^ADDR_W-1) one per cycle, then arbitrates the
//   single write port round-robin between execute and load writeback.
//   Ports:
//     clk, reset                     : clock, asynchronous active-high reset
//     ex_valid/ex_ready/ex_rd/ex_data     : execute writeback handshake
//     mem_valid/mem_ready/mem_rd/mem_data : load writeback handshake
//     iss_valid/iss_rd/iss_ready     : decode claims a destination register
//     rs1/rs2, hazard_1/hazard_2     : source addresses and pending-producer flags
//     rf_we/rf_rd/rf_write_data      : registered register-file write port
//     init_done                      : clear walk finished
//   Build option: define REGFILE_CTRL_SCOREBOARD_EN to implement the busy
//   scoreboard; otherwise hazards read 0 and the issue claim is ignored.
module regfile_ctrl
   import regfile_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [XLEN-1:0]   ex_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   output logic              iss_ready,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              hazard_1,
   output logic              hazard_2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]   rf_write_data,
   output logic              init_done
);

   localparam int                NREGS     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

   state_e              state_r, state_s;
   logic [ADDR_W-1:0]   cnt_r;
   logic                rf_we_r;
   logic [ADDR_W-1:0]   rf_rd_r;
   logic [XLEN-1:0]     rf_data_r;
   logic                init_done_r;
   logic                run_s;
   logic [1:0]          req_s;
   logic [1:0]          grant_s;
   logic                hs_s;
   logic [ADDR_W-1:0]   wb_rd_s;
   logic [XLEN-1:0]     wb_data_s;

   assign run_s = (state_r == RUN);
   assign req_s = run_s ? {mem_valid, ex_valid} : 2'b00;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_s),
      .advance (hs_s),
      .grant   (grant_s)
   );

   // A grant is only ever given to a valid requester, so any grant is a handshake.
   assign ex_ready  = grant_s[0];
   assign mem_ready = grant_s[1];
   assign hs_s      = |grant_s;
   assign iss_ready = init_done_r;
   assign init_done = init_done_r;

   assign rf_we         = rf_we_r;
   assign rf_rd         = rf_rd_r;
   assign rf_write_data = rf_data_r;

   // Writeback source mux driven by the arbiter grant.
   always_comb begin
      wb_rd_s   = ex_rd;
      wb_data_s = ex_data;
      if (grant_s[1]) begin
         wb_rd_s   = mem_rd;
         wb_data_s = mem_data;
      end else begin
         wb_rd_s   = ex_rd;
         wb_data_s = ex_data;
      end
   end

   // FSM next state: leave INIT after the last register has been cleared.
   always_comb begin
      state_s = state_r;
      case (state_r)
         INIT: begin
            if (cnt_r == LAST_IDX) begin
               state_s = RUN;
            end else begin
               state_s = INIT;
            end
         end
         RUN:     state_s = RUN;
         default: state_s = INIT;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= INIT;
      end else begin
         state_r <= state_s;
      end
   end

   // Clear-walk counter; x0 is hard-wired so the walk starts at x1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= FIRST_IDX;
      end else if (state_r == INIT) begin
         cnt_r <= cnt_r + ADDR_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Registered write port: clear walk in INIT, arbitrated writeback in RUN.
   // Writes to x0 are accepted but suppressed at the enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we_r   <= 1'b0;
         rf_rd_r   <= '0;
         rf_data_r <= '0;
      end else if (!run_s) begin
         rf_we_r   <= 1'b1;
         rf_rd_r   <= cnt_r;
         rf_data_r <= '0;
      end else if (hs_s) begin
         rf_we_r   <= (wb_rd_s != '0);
         rf_rd_r   <= wb_rd_s;
         rf_data_r <= wb_data_s;
      end else begin
         rf_we_r   <= 1'b0;
         rf_rd_r   <= rf_rd_r;
         rf_data_r <= rf_data_r;
      end
   end

   // Init-done flag, rising together with the first RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_done_r <= 1'b0;
      end else begin
         init_done_r <= (state_s == RUN);
      end
   end

`ifdef REGFILE_CTRL_SCOREBOARD_EN
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] set_mask_s;
   logic [NREGS-1:0] clr_mask_s;

   // Busy set/clear masks; the clear tracks the write actually reaching the file.
   always_comb begin
      set_mask_s = '0;
      clr_mask_s = '0;
      if (iss_valid && iss_ready && (iss_rd != '0)) begin
         set_mask_s[iss_rd] = 1'b1;
      end else begin
         set_mask_s = '0;
      end
      if (run_s && rf_we_r) begin
         clr_mask_s[rf_rd_r] = 1'b1;
      end else begin
         clr_mask_s = '0;
      end
   end

   // Busy bits: set is applied after clear so a new producer wins; bit 0 stays 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r <= '0;
      end else begin
         busy_r <= ((busy_r & ~clr_mask_s) | set_mask_s) & {{(NREGS-1){1'b1}}, 1'b0};
      end
   end

   assign hazard_1 = busy_r[rs1];
   assign hazard_2 = busy_r[rs2];
`else
   logic unused_s;

   assign hazard_1 = 1'b0;
   assign hazard_2 = 1'b0;
   assign unused_s = ^{iss_valid, iss_rd, rs1, rs2};
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: self-checking bench for regfile_ctrl.
// A behavioural model (counters, a busy array, a last-winner flag) predicts
// every output each cycle; directed steps are followed by random traffic.
module tb_regfile_ctrl;

`ifdef REGFILE_CTRL_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif
   localparam int INIT_CYCLES = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, mem_valid, mem_ready;
   logic [3:0]  ex_rd, mem_rd, iss_rd, rs1, rs2, rf_rd;
   logic [31:0] ex_data, mem_data, rf_write_data;
   logic        iss_valid, iss_ready, hazard_1, hazard_2, rf_we, init_done;

   int checks = 0;
   int errors = 0;

   // model state
   int          m_init;      // clear-walk cycles completed
   bit          m_last_mem;  // last served requester was MEM
   bit          m_busy [16];
   bit          m_we;
   logic [3:0]  m_rd;
   logic [31:0] m_data;
   bit          ex_hs, mem_hs;

   regfile_ctrl dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1(rs1), .rs2(rs2), .hazard_1(hazard_1), .hazard_2(hazard_2),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_write_data(rf_write_data), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_init     = 0;
      m_last_mem = 1'b1;
      m_we       = 1'b0;
      m_rd       = 4'd0;
      m_data     = 32'd0;
      ex_hs      = 1'b0;
      mem_hs     = 1'b0;
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_rf_we", rf_we, 32'd0);
      check("rst_rf_rd", rf_rd, 32'd0);
      check("rst_rf_data", rf_write_data, 32'd0);
      check("rst_init_done", init_done, 32'd0);
      check("rst_ex_ready", ex_ready, 32'd0);
      check("rst_mem_ready", mem_ready, 32'd0);
      check("rst_iss_ready", iss_ready, 32'd0);
      check("rst_hazard_1", hazard_1, 32'd0);
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_rd = 4'd0; ex_data = 32'd0;
      mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 32'd0;
      iss_valid = 1'b0; iss_rd = 4'd0; rs1 = 4'd0; rs2 = 4'd0;
   endtask

   // One clock cycle: check all outputs mid-cycle, then advance the model.
   task automatic tick();
      bit run;
      int win;
      bit h1, h2;
      @(negedge clk);
      run = (m_init == INIT_CYCLES);
      win = -1;
      if (run) begin
         if (ex_valid && mem_valid) win = m_last_mem ? 0 : 1;
         else if (ex_valid)         win = 0;
         else if (mem_valid)        win = 1;
      end
      h1 = SB_EN && (rs1 != 4'd0) && m_busy[rs1];
      h2 = SB_EN && (rs2 != 4'd0) && m_busy[rs2];
      check("ex_ready", ex_ready, 32'(win == 0));
      check("mem_ready", mem_ready, 32'(win == 1));
      check("iss_ready", iss_ready, 32'(run));
      check("init_done", init_done, 32'(run));
      check("hazard_1", hazard_1, 32'(h1));
      check("hazard_2", hazard_2, 32'(h2));
      check("rf_we", rf_we, 32'(m_we));
      if (m_we) begin
         check("rf_rd", rf_rd, 32'(m_rd));
         check("rf_write_data", rf_write_data, m_data);
      end
      // scoreboard: the write leaving the port now retires its producer;
      // a claim in the same cycle re-marks it afterwards
      if (run && m_we) m_busy[m_rd] = 1'b0;
      if (run && iss_valid && iss_rd != 4'd0) m_busy[iss_rd] = 1'b1;
      ex_hs  = (win == 0);
      mem_hs = (win == 1);
      if (!run) begin
         m_we   = 1'b1;
         m_rd   = 4'(m_init + 1);
         m_data = 32'd0;
         m_init++;
      end else if (win == 0) begin
         m_we = (ex_rd != 4'd0); m_rd = ex_rd; m_data = ex_data; m_last_mem = 1'b0;
      end else if (win == 1) begin
         m_we = (mem_rd != 4'd0); m_rd = mem_rd; m_data = mem_data; m_last_mem = 1'b1;
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      reset = 1'b1;
      #1;
      check_reset_values();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // clear walk, with requesters and an issue claim pending to prove they wait
      ex_valid = 1'b1; ex_rd = 4'd2; ex_data = 32'h1111_1111;
      mem_valid = 1'b1; mem_rd = 4'd9; mem_data = 32'h2222_2222;
      iss_valid = 1'b1; iss_rd = 4'd12; rs1 = 4'd12;
      for (int i = 0; i < INIT_CYCLES - 1; i++) tick();
      idle_inputs();
      tick();   // last INIT cycle
      tick();   // first RUN cycle, idle
      tick();

      // EX only, rd=5
      ex_valid = 1'b1; ex_rd = 4'd5; ex_data = 32'h0000_0005;
      tick();
      idle_inputs();
      tick();
      tick();

      // MEM only, then a held dual request
      mem_valid = 1'b1; mem_rd = 4'd6; mem_data = 32'h6666_6666;
      tick();
      ex_valid = 1'b1; ex_rd = 4'd3; ex_data = 32'hAAAA_AAAA;
      mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 32'hBBBB_BBBB;
      for (int i = 0; i < 4; i++) tick();
      idle_inputs();
      tick();

      // hazard on rd=7
      iss_valid = 1'b1; iss_rd = 4'd7; rs1 = 4'd7; rs2 = 4'd7;
      tick();
      iss_valid = 1'b0;
      tick();
      ex_valid = 1'b1; ex_rd = 4'd7; ex_data = 32'h7777_7777;
      tick();
      ex_valid = 1'b0;
      tick();
      tick();
      // writeback of 7 followed by a re-claim in the cycle the write retires
      iss_valid = 1'b1; iss_rd = 4'd7;
      tick();
      iss_valid = 1'b0;
      ex_valid = 1'b1; ex_rd = 4'd7; ex_data = 32'h7070_7070;
      tick();
      ex_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 4'd7;
      tick();
      iss_valid = 1'b0;
      tick();
      tick();

      // writeback to x0 and an issue to x0
      ex_valid = 1'b1; ex_rd = 4'd0; ex_data = 32'h9999_9999;
      iss_valid = 1'b1; iss_rd = 4'd0; rs1 = 4'd0;
      tick();
      idle_inputs();
      tick();
      tick();

      // random traffic with requesters holding their payload until served
      for (int i = 0; i < 400; i++) begin
         if (!ex_valid || ex_hs) begin
            ex_valid = 1'($urandom_range(0, 1));
            ex_rd    = 4'($urandom_range(0, 15));
            ex_data  = $urandom;
         end
         if (!mem_valid || mem_hs) begin
            mem_valid = 1'($urandom_range(0, 1));
            mem_rd    = 4'($urandom_range(0, 15));
            mem_data  = $urandom;
         end
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd    = 4'($urandom_range(0, 15));
         rs1       = 4'($urandom_range(0, 15));
         rs2       = 4'($urandom_range(0, 15));
         tick();
      end

      // reset in the middle of a dual-request burst
      ex_valid = 1'b1; ex_rd = 4'd3; ex_data = 32'hAAAA_AAAA;
      mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 32'hBBBB_BBBB;
      rs1 = 4'd7;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check_reset_values();
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < INIT_CYCLES + 6; i++) tick();
      idle_inputs();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Write-port controller and hazard scoreboard for the 16-entry, 32-bit CPU register file. After reset it walks the file, writing zero to x1..x15. It then arbitrates the single write port between the execute writeback and the load writeback requesters, round-robin. It also tracks which registers have an outstanding producer, so decode can stall on rs1/rs2 hazards. It sits between decode/execute/memory stages and the `registers` block, driving that block's `we`, `rd` and `write_data`.

## Interface
- XLEN, 32, data width
- ADDR_W, 4, register address width; file depth 2^ADDR_W
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ex_valid / ex_ready  in/out  1  execute writeback handshake
- ex_rd  in  ADDR_W  execute destination
- ex_data  in  XLEN  execute result
- mem_valid / mem_ready  in/out  1  load writeback handshake
- mem_rd  in  ADDR_W  load destination
- mem_data  in  XLEN  load result
- iss_valid  in  1  decode issues an instruction that writes iss_rd
- iss_rd  in  ADDR_W  destination being claimed
- iss_ready  out  1  controller accepts issue claims
- rs1 / rs2  in  ADDR_W  decode source addresses
- hazard_1 / hazard_2  out  1  rs1 / rs2 has a pending producer
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  ADDR_W  register file write address (registered)
- rf_write_data  out  XLEN  register file write data (registered)
- init_done  out  1  high once the clear walk has finished

## Operation
- FSM states: INIT, RUN. Reset enters INIT.
- INIT:
  - Counter runs 1..2^ADDR_W-1. Each cycle drives rf_we=1, rf_rd=counter, rf_write_data=0.
  - After the write to the last register, the FSM moves to RUN and init_done goes to 1.
  - ex_ready, mem_ready and iss_ready are 0 throughout INIT.
- RUN arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted. The last-grant register resets to MEM, so EX wins the first tie.
  - The ready of the granted requester equals its valid (combinational); the other ready is 0.
  - A handshake (valid & ready) loads rf_we/rf_rd/rf_write_data on the next edge.
  - Cycles without a handshake load rf_we=0; rf_rd and rf_write_data hold.
- x0:
  - A handshake with rd==0 is accepted, but rf_we stays 0.
  - x0 is never marked busy.
- Scoreboard (busy[2^ADDR_W-1:0], bit 0 tied 0):
  - Set: iss_valid & iss_ready & iss_rd!=0 sets busy[iss_rd].
  - Clear: a cycle with rf_we=1 in RUN clears busy[rf_rd]. The clear coincides with the file write.
  - Set and clear of the same index in one cycle: set wins, because a new producer exists.
  - Re-issue to an already-busy rd is legal; the bit stays 1.
  - hazard_1 = busy[rs1], hazard_2 = busy[rs2], combinational. Address 0 always reads 0.
- Requesters must hold rd and data stable while valid is high and ready is low.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_write_data=0, ex_ready=0, mem_ready=0, iss_ready=0, init_done=0, busy=0, last grant=MEM.
- INIT takes 2^ADDR_W-1 cycles (15 by default). The first RUN cycle follows, with readies live in that cycle.
- Writeback latency:
  - Handshake in cycle N gives rf_we=1 in cycle N+1; the file is written at the end of N+1.
  - The busy bit clears at the end of N+1, so the hazard drops in N+2.
- Throughput is one write per cycle. Under continuous dual request, EX and MEM alternate.
- Reset asserted mid-operation clears all state immediately (asynchronously) and restarts INIT. The in-flight write is dropped.

## Configuration
- REGFILE_CTRL_SCOREBOARD_EN defined: the scoreboard and hazard outputs are implemented as above.
- Not defined:
  - No busy register.
  - hazard_1 and hazard_2 are tied 0.
  - iss_valid and iss_rd are ignored.
  - iss_ready still follows init_done.

## Structure
- Package regfile_pkg holds:
  - XLEN and ADDR_W defaults
  - NUM_REGS = 2^ADDR_W
  - the FSM state enum {INIT, RUN}
  - the requester id enum {REQ_EX, REQ_MEM}
- One sub-module, rr_arbiter2: 2-way round-robin, with inputs req[1:0] and advance, output grant[1:0], and the last-grant register inside.

## Test plan
- Reset release -> rf_we=1 for 15 cycles with rf_rd 1..15 and data 0, then init_done=1; readies stay 0 until that point.
- EX only, rd=5, data 0x00000005, handshake in cycle N -> rf_we=1, rf_rd=5, rf_write_data=0x00000005 in N+1 only.
- EX and MEM both held valid (rd=3 / 0xAAAAAAAA and rd=4 / 0xBBBBBBBB) for 4 cycles -> writes go EX, MEM, EX, MEM.
- Issue rd=7, then rs1=7 -> hazard_1=1; EX writeback rd=7 handshake in cycle N -> hazard_1=0 from N+2. Issue and writeback of rd=7 in the same cycle -> busy[7] stays 1.
- EX writeback rd=0, data 0x99999999 -> ex_ready=1 and the handshake completes, rf_we stays 0; rs1=0 -> hazard_1=0.
- Assert reset during a dual-request burst -> all outputs go to reset values immediately; after release, INIT replays the full 15-cycle clear.
